// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM encodings and the pulse
// timing counter width.
package pulse_stretcher_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ON   = ST_ON,
        GAP  = ST_GAP
    } state_t;

endpackage

// File: rtl/pulse_stretcher_sat_updown_cnt.sv
// Saturating up/down counter: holds at both ends, and flags an increment
// that is lost because the counter is already full.
module sat_updown_cnt #(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q,
    output logic         sat_drop
);

    localparam logic [W-1:0] MAX = '1;

    assign sat_drop = inc && !dec && (q == MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= '0;
        end else if (inc && !dec && (q != MAX)) begin
            q <= q + W'(1);
        end else if (dec && !inc && (q != '0)) begin
            q <= q - W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into ON_LEN-cycle pulses separated by at least
// OFF_LEN low cycles, queueing overlapping strobes. Optional PULSE_STRETCHER_OVF_EN adds OVF.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int ON_LEN  = 8,
    parameter int OFF_LEN = 4,
    parameter int PEND_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I,
    output logic              O,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND
`ifdef PULSE_STRETCHER_OVF_EN
    ,
    output logic              OVF
`endif
);

    localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(ON_LEN - 1);
    localparam logic [CNT_W-1:0] OFF_RELOAD = CNT_W'(OFF_LEN - 1);

    // valid/ready note: I has no handshake; every sampled high cycle is one event.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_q;
    logic             inc, dec, sat_drop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (I) begin
                    state_d = ON;
                    cnt_d   = ON_RELOAD;
                end
            end
            ON: begin
                inc = I;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = GAP;
                    cnt_d   = OFF_RELOAD;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    inc   = I;
                end else if ((PEND != '0) || I) begin
                    // A strobe on the restart cycle feeds the new pulse directly.
                    state_d = ON;
                    cnt_d   = ON_RELOAD;
                    dec     = !I;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= (state_d == ON);
        end
    end

    sat_updown_cnt #(.W(PEND_W)) u_pend (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (inc),
        .dec      (dec),
        .q        (PEND),
        .sat_drop (sat_drop)
    );

    assign O    = o_q;
    assign BUSY = (state_q == ON) || (state_q == GAP);

`ifdef PULSE_STRETCHER_OVF_EN
    logic ovf_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (sat_drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign OVF = ovf_q;
`else
    logic unused_sat_drop;
    assign unused_sat_drop = sat_drop;
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: random and directed strobes against a timeline
// model of the pulse schedule, checked through an expected-value queue.
module tb_pulse_stretcher;

    localparam int ON_LEN  = 8;
    localparam int OFF_LEN = 4;
    localparam int PEND_W  = 3;
    localparam int PMAX    = (1 << PEND_W) - 1;
    localparam int EW      = PEND_W + 3;
`ifdef PULSE_STRETCHER_OVF_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              I;
    logic              O;
    logic              BUSY;
    logic [PEND_W-1:0] PEND;
`ifdef PULSE_STRETCHER_OVF_EN
    logic              OVF;
`endif

    pulse_stretcher #(.ON_LEN(ON_LEN), .OFF_LEN(OFF_LEN), .PEND_W(PEND_W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .I    (I),
        .O    (O),
        .BUSY (BUSY),
        .PEND (PEND)
`ifdef PULSE_STRETCHER_OVF_EN
        ,
        .OVF  (OVF)
`endif
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // scoreboard storage: {ovf, o, busy, pend}
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model: schedule of the current pulse on an absolute cycle axis
    int cyc    = 0;
    bit have   = 1'b0;
    int s      = 0;
    int m_pend = 0;
    bit m_ovf  = 1'b0;

    function automatic logic [EW-1:0] actual();
        logic ovf_bit;
`ifdef PULSE_STRETCHER_OVF_EN
        ovf_bit = OVF;
`else
        ovf_bit = 1'b0;
`endif
        return {ovf_bit, O, BUSY, PEND};
    endfunction

    task automatic model_step(input bit i);
        int  e;
        bit  active;
        bit  eo, eb;
        e      = s + ON_LEN + OFF_LEN - 1;
        active = have && (cyc >= s) && (cyc <= e);
        if (!active) begin
            if (i) begin
                have = 1'b1;
                s    = cyc + 1;
            end
        end else if ((cyc == e) && ((m_pend > 0) || i)) begin
            s = cyc + 1;
            if (!i) m_pend = m_pend - 1;
        end else if (i) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend = m_pend + 1;
        end
        cyc = cyc + 1;
        eo  = have && (cyc >= s) && (cyc <= s + ON_LEN - 1);
        eb  = have && (cyc >= s) && (cyc <= s + ON_LEN + OFF_LEN - 1);
        exp_q.push_back({HAS_OVF & m_ovf, eo, eb, PEND_W'(m_pend)});
    endtask

    // monitor: outputs are valid every cycle, sampled on the falling edge
    always @(negedge CLK) begin
        logic [EW-1:0] ev, av;
        if (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            av = actual();
            n_cmp++;
            if (av !== ev) begin
                n_bad++;
                $display("FAIL outputs t=%0t: got ovf=%b o=%b busy=%b pend=%0d, want ovf=%b o=%b busy=%b pend=%0d",
                         $time, av[EW-1], av[EW-2], av[EW-3], av[PEND_W-1:0],
                         ev[EW-1], ev[EW-2], ev[EW-3], ev[PEND_W-1:0]);
            end
        end
    end

    // driver tasks
    task automatic step(input bit i);
        I = i;
        @(posedge CLK);
        model_step(i);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic check_zero(input string name);
        logic [EW-1:0] av;
        av = actual();
        n_cmp++;
        if (av !== '0) begin
            n_bad++;
            $display("FAIL %s: got ovf=%b o=%b busy=%b pend=%0d, want all zero",
                     name, av[EW-1], av[EW-2], av[EW-3], av[PEND_W-1:0]);
        end
    endtask

    // Asserted between clock edges so the outputs must clear asynchronously.
    task automatic do_reset(input string name);
        RST = 1'b1;
        exp_q.delete();
        have   = 1'b0;
        m_pend = 0;
        m_ovf  = 1'b0;
        #1;
        check_zero(name);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int dens[6];
        dens = '{5, 15, 30, 60, 90, 2};
        RST = 1'b1;
        I   = 1'b0;
        #1;
        check_zero("power_on_reset");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // single strobe
        step(1'b1);
        idle(20);
        // strobes at cycles 0, 2, 3
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        idle(40);
        // input held for five cycles
        repeat (5) step(1'b1);
        idle(70);
        // overfill the queue during the first pulse
        repeat (10) step(1'b1);
        idle(8 * (ON_LEN + OFF_LEN) + 10);
        // strobe on the last gap cycle with nothing queued
        step(1'b1);
        idle(ON_LEN + OFF_LEN - 1);
        step(1'b1);
        idle(20);
        // reset mid-pulse with three queued events
        repeat (4) step(1'b1);
        idle(2);
        do_reset("reset_mid_on");
        idle(20);

        // randomized density sweep with one reset in the middle
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 400; k++) step($urandom_range(0, 99) < dens[b]);
            if (b == 3) do_reset("reset_random");
        end
        idle(8 * (ON_LEN + OFF_LEN) + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
